// File: rtl/tlm_pkg.sv
// Shared types and default widths for the TLM result-collection path.
package tlm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } coll_state_e;

    localparam int DEF_ITEM_WIDTH = 8;
    localparam int DEF_CHK_W      = 16;

endpackage

// File: rtl/tlm_valid_delay.sv
// DEPTH-stage valid shift register that lines a launch strobe up with its bfm result.
module tlm_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH:0]   shifted;

    assign shifted = {pipe_q, valid_i};
    assign valid_o = pipe_q[DEPTH-1];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pipe_q <= '0;
        end else if (flush_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= shifted[DEPTH-1:0];
        end
    end

endmodule

// File: rtl/tlm_result_collector.sv
// Collects one batch of NUM bfm results into a flat buffer with a running checksum.
module tlm_result_collector
    import tlm_pkg::*;
#(
    parameter int NUM        = 1000,
    parameter int ITEM_WIDTH = DEF_ITEM_WIDTH,
    parameter int LATENCY    = 1,
    parameter int CHK_W      = DEF_CHK_W,
    parameter int CNT_W      = $clog2(NUM + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      xmit_valid_i,
    input  logic [ITEM_WIDTH-1:0]     res_i,
    input  logic                      ack_i,
    output logic [NUM*ITEM_WIDTH-1:0] result_data_o,
    output logic [CNT_W-1:0]          count_o,
    output logic [CHK_W-1:0]          checksum_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overrun_o
);

    coll_state_e state_q, state_d;
    logic        cap;
    logic        capture;
    logic        overrun_set;

    tlm_valid_delay #(.DEPTH(LATENCY)) u_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (start_i),
        .valid_i (xmit_valid_i),
        .valid_o (cap)
    );

    // start_i overrides everything, including a result arriving on the same edge.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        if (start_i) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (cap) begin
                        capture = 1'b1;
                        if (count_o == CNT_W'(NUM - 1)) state_d = DONE;
                    end
                end
                DONE: begin
                    overrun_set = cap;
                    if (ack_i) state_d = IDLE;
                end
                default: overrun_set = cap;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            count_o    <= '0;
            checksum_o <= '0;
            overrun_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_i) begin
                count_o    <= '0;
                checksum_o <= '0;
                overrun_o  <= 1'b0;
            end else begin
                if (capture) begin
                    count_o    <= count_o + 1'b1;
                    checksum_o <= checksum_o + CHK_W'(res_i);
                end
                if (overrun_set) overrun_o <= 1'b1;
            end
        end
    end

    // Buffer is left intact on start; stale items get overwritten slot by slot.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            result_data_o <= '0;
        end else if (capture) begin
            for (int k = 0; k < NUM; k++) begin
                if (count_o == CNT_W'(k)) result_data_o[k*ITEM_WIDTH +: ITEM_WIDTH] <= res_i;
            end
        end
    end

    assign busy_o = (state_q == COLLECT);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_tlm_result_collector.sv
// Randomized bench for tlm_result_collector against a queue-based batch model.
module tb_tlm_result_collector;

    localparam int NUM = 4;
    localparam int IW  = 8;
    localparam int LAT = 1;
    localparam int CW  = 3;
    localparam int VW  = NUM*IW + CW + 16 + 3;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    logic start_i = 1'b0, xmit_valid_i = 1'b0, ack_i = 1'b0;
    logic [IW-1:0] res_i = '0;
    logic [NUM*IW-1:0] result_data;
    logic [CW-1:0] count;
    logic [15:0] checksum;
    logic busy, done, overrun;

    logic start2 = 1'b0, xv2 = 1'b0, ack2 = 1'b0;
    logic [IW-1:0] res2 = '0;
    logic [NUM*IW-1:0] data2;
    logic [CW-1:0] count2;
    logic [7:0] sum2;
    logic busy2, done2, ovr2;

    always #5 clk = ~clk;

    tlm_result_collector #(.NUM(NUM), .ITEM_WIDTH(IW), .LATENCY(LAT), .CHK_W(16)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .xmit_valid_i(xmit_valid_i),
        .res_i(res_i), .ack_i(ack_i), .result_data_o(result_data), .count_o(count),
        .checksum_o(checksum), .busy_o(busy), .done_o(done), .overrun_o(overrun));

    tlm_result_collector #(.NUM(NUM), .ITEM_WIDTH(IW), .LATENCY(3), .CHK_W(8)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start2), .xmit_valid_i(xv2),
        .res_i(res2), .ack_i(ack2), .result_data_o(data2), .count_o(count2),
        .checksum_o(sum2), .busy_o(busy2), .done_o(done2), .overrun_o(ovr2));

    int n_run = 0, n_fail = 0;

    // Behavioural model: batch phase, captured items, and arrival times of in-flight launches.
    localparam int M_IDLE = 0, M_COLL = 1, M_DONE = 2;
    int m_phase, m_cnt, m_sum, cyc = 0;
    bit m_ovr;
    logic [NUM*IW-1:0] m_data;
    int pend[$];

    function automatic void model_reset();
        m_phase = M_IDLE; m_cnt = 0; m_sum = 0; m_ovr = 0; m_data = '0;
        pend.delete();
    endfunction

    function automatic void model_edge();
        bit arrived = 0;
        int prev = m_phase;
        if (!reset_i) begin
            model_reset();
        end else begin
            if (pend.size() > 0 && pend[0] == cyc) begin
                arrived = 1;
                void'(pend.pop_front());
            end
            if (start_i) begin
                m_phase = M_COLL; m_cnt = 0; m_sum = 0; m_ovr = 0;
                pend.delete();
            end else begin
                if (arrived) begin
                    if (prev == M_COLL) begin
                        m_data[m_cnt*IW +: IW] = res_i;
                        m_cnt++;
                        m_sum = (m_sum + int'(res_i)) % 65536;
                        if (m_cnt == NUM) m_phase = M_DONE;
                    end else begin
                        m_ovr = 1;
                    end
                end
                if (prev == M_DONE && ack_i) m_phase = M_IDLE;
                if (xmit_valid_i) pend.push_back(cyc + LAT);
            end
        end
        cyc++;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {result_data, count, checksum, busy, done, overrun};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_data, CW'(m_cnt), 16'(m_sum), m_phase == M_COLL, m_phase == M_DONE, m_ovr};
    endfunction

    task automatic step(input logic s, input logic x, input logic [IW-1:0] r, input logic a);
        start_i = s; xmit_valid_i = x; res_i = r; ack_i = a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom), 1'($urandom), IW'($urandom), 1'($urandom));
            n_run++;
            if (obs_vec() !== '0) begin
                n_fail++; $display("FAIL reset_hold got %h want 0", obs_vec());
            end
        end
        reset_i = 1'b1;
        step(0, 0, IW'($urandom), 0);
        step(0, 0, IW'($urandom), 0);
        n_run++;
        if (count !== '0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_nominal();
        logic [IW-1:0] seq [0:5];
        logic [4:0] xs;
        seq = '{8'h5A, 8'h10, 8'h20, 8'h30, 8'h40, 8'h77};
        xs = 5'b01111;
        step(1, 0, IW'($urandom), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, xs[i], seq[i], 0);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL nominal_step%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_run++;
        if (result_data !== 32'h40302010 || count !== 3'd4 || checksum !== 16'h00A0 || done !== 1'b1) begin
            n_fail++; $display("FAIL nominal_final got %h/%0d/%h/%b want 40302010/4/00a0/1",
                               result_data, count, checksum, done);
        end
        step(0, 0, 8'h00, 1);
        n_run++;
        if (done !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL nominal_ack got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_bubbles();
        logic [IW-1:0] rs [0:7];
        logic [7:0] xs;
        rs = '{8'h99, 8'h01, 8'hEE, 8'h02, 8'h03, 8'hEE, 8'hEE, 8'h04};
        xs = 8'b01001101;
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, xs[i], rs[i], 0);
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bubble_step%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_run++;
        if (result_data !== 32'h04030201 || done !== 1'b1) begin
            n_fail++; $display("FAIL bubble_final got %h done=%b want 04030201 1", result_data, done);
        end
    endtask

    task automatic test_overrun();
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'hAB, 0);
        n_run++;
        if (overrun !== 1'b1 || result_data !== 32'h04030201 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL overrun_set got ovr=%b data=%h want 1 04030201", overrun, result_data);
        end
        step(1, 0, 8'h00, 0);
        n_run++;
        if (overrun !== 1'b0 || count !== '0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL overrun_clear got ovr=%b cnt=%0d want 0 0", overrun, count);
        end
    endtask

    task automatic test_restart_and_reset();
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 0, 8'h22, 0);
        step(1, 1, 8'h33, 0);
        n_run++;
        if (count !== '0 || checksum !== '0 || busy !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL restart_clear got cnt=%0d sum=%h want 0 0", count, checksum);
        end
        for (int i = 0; i < 6 && !done; i++) step(0, 1'(i < 4), IW'($urandom), 0);
        n_run++;
        if (done !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL restart_batch got %h want %h", obs_vec(), exp_vec());
        end
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h5C, 0);
        step(0, 0, 8'h6D, 0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        n_run++;
        if (obs_vec() !== '0) begin
            n_fail++; $display("FAIL async_reset got %h want 0", obs_vec());
        end
        step(0, 0, 8'h00, 0);
        reset_i = 1'b1;
        step(0, 0, 8'h00, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 11) == 0), 1'($urandom), IW'($urandom),
                 1'($urandom_range(0, 3) == 0));
            n_run++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_latency_wrap();
        int first = -1;
        start2 = 1'b1;
        step(0, 0, 8'h00, 0);
        start2 = 1'b0;
        for (int i = 0; i < 20 && !done2; i++) begin
            xv2 = 1'(i < 4);
            res2 = 8'hFF;
            step(0, 0, 8'h00, 0);
            if (first < 0 && count2 != '0) first = i;
        end
        xv2 = 1'b0;
        n_run++;
        if (first !== 3) begin
            n_fail++; $display("FAIL latency3_first got %0d want 3", first);
        end
        n_run++;
        if (done2 !== 1'b1 || sum2 !== 8'hFC || count2 !== 3'd4 || data2 !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL chk_wrap got done=%b sum=%h cnt=%0d want 1 fc 4", done2, sum2, count2);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bubbles();
        test_overrun();
        test_restart_and_reset();
        test_random();
        test_latency_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tlm_result_collector.md
Name: tlm_result_collector

Overview:
- Downstream stage of the TLM stimulus wrapper. Consumes the bfm result stream (res_o) and aligns each result to its launched operand pair.
- Packs one batch of NUM results into a flat buffer for DPI readback and keeps a running checksum.
- Raises done when the batch is complete, so the testbench can hand the next batch to gen_tlm_data.

Parameters:
- NUM, 1000, results per batch (equals operand-pair count per batch).
- ITEM_WIDTH, 8, width of one result item.
- LATENCY, 1, cycles from operand launch (xmit_valid_i) to a valid res_i; must be ≥1.
- CHK_W, 16, checksum width.
- CNT_W, $clog2(NUM+1), derived; do not override.

Ports:
- clk_i  input  1  clock, all state on posedge.
- reset_i  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle pulse; arms the collector for a new batch.
- xmit_valid_i  input  1  high in the cycle an A/B pair is launched to the bfm.
- res_i  input  ITEM_WIDTH  bfm result.
- ack_i  input  1  host has read results; releases DONE.
- result_data_o  output  NUM*ITEM_WIDTH  packed results; item k at [k*ITEM_WIDTH +: ITEM_WIDTH].
- count_o  output  CNT_W  items captured in the current batch.
- checksum_o  output  CHK_W  sum of captured items, mod 2^CHK_W.
- busy_o  output  1  high in COLLECT.
- done_o  output  1  high in DONE.
- overrun_o  output  1  sticky; a result arrived with no space for it.

Behaviour:
- Reset (reset_i=0, async): all outputs 0, delay line 0, state IDLE.
- States:
  - IDLE: start_i → COLLECT.
  - COLLECT: final capture → DONE. start_i → COLLECT (restart).
  - DONE: start_i → COLLECT; otherwise ack_i → IDLE. If start_i and ack_i are both high, start_i wins.
- Entering or restarting COLLECT on a start_i edge:
  - count_o and checksum_o are cleared to 0.
  - overrun_o is cleared.
  - The valid delay line is flushed to 0.
  - result_data_o is not cleared; stale items are overwritten as new results arrive.
- Alignment:
  - xmit_valid_i passes through a LATENCY-stage shift register.
  - cap = the delay-line output. It is high at cycle t+LATENCY when xmit_valid_i was high at t.
- Capture (state COLLECT, cap=1): on the edge,
  - result_data_o item[count_o] ← res_i;
  - count_o +1;
  - checksum_o += zero-extended res_i, wrapping mod 2^CHK_W.
- Final capture: the capture with count_o==NUM-1. On the same edge, count_o→NUM and the state→DONE. done_o is therefore high in the first cycle after the last result is sampled.
- cap=0 cycles (bubbles, xmit_en low): no change.
- cap=1 in IDLE or DONE: overrun_o←1; data, count and checksum unchanged.
- start_i with cap=1 on the same edge: start_i wins and the in-flight result is discarded (no overrun).
- ack_i in IDLE or COLLECT is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package tlm_pkg:
  - state enum coll_state_e {IDLE, COLLECT, DONE};
  - default ITEM_WIDTH and CHK_W constants.
- One sub-module: tlm_valid_delay.
  - Parameter DEPTH (=LATENCY).
  - Ports clk_i, reset_i, flush_i, valid_i, valid_o.
  - Flush is synchronous; reset is asynchronous, active-low.

Test Plan (NUM=4, LATENCY=1, ITEM_WIDTH=8 unless stated):
1. Reset check: hold reset_i=0 with random inputs → all outputs 0. Release reset, no start_i → count_o=0, busy_o=0.
2. Nominal batch: start_i, then 4 consecutive xmit_valid_i with res_i=0x10,0x20,0x30,0x40 one cycle later → result_data_o=0x40302010, count_o=4, checksum_o=0x00A0, done_o=1 one cycle after the last sample; ack_i → done_o=0, busy_o=0.
3. Bubbles: valids on cycles 0,2,3,6 with res_i sequence 0x01,0xEE(bubble),0x02,0x03,0xEE,0xEE,0x04 → captured 0x04030201, 0xEE never stored.
4. Overrun: after DONE, one more xmit_valid_i → overrun_o=1, result_data_o unchanged. Next start_i → overrun_o=0, count_o=0.
5. Restart and reset mid-batch: after 2 captures, start_i → count_o=0, checksum_o=0, batch completes normally with 4 new items. Separately, reset_i low mid-batch → outputs 0 immediately, without waiting for a clock edge.
6. Checksum wrap (CHK_W=8): four results of 0xFF → checksum_o=0xFC. With LATENCY=3 → first capture exactly 3 cycles after the first xmit_valid_i.
